// File: rtl/voq_grant_exec.sv
// Executes 4x4 VOQ scheduler grants: per-ingress packet dequeue, crossbar select, and scheduler epoch/snapshot generation.
// Define GRANT_CHECK_EN to build the sticky grant_err_o checker; otherwise grant_err_o is tied low.
module voq_grant_exec #(
   parameter int PKT_WORDS    = 4,
   parameter int SCHED_PERIOD = 8,
   parameter int SCHED_LAT    = 7
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [15:0] voq_empty_in_i,
   input  logic [3:0]  sched_sel_en_i,
   input  logic [7:0]  sched_sel_i,
   output logic        sched_en_o,
   output logic [3:0]  is_busy_o,
   output logic [7:0]  busy_voq_num_o,
   output logic [15:0] voq_empty_o,
   output logic [3:0]  deq_en_o,
   output logic [7:0]  deq_voq_o,
   output logic [3:0]  xbar_valid_o,
   output logic [7:0]  xbar_src_o,
   output logic [3:0]  xbar_last_o,
   output logic        grant_err_o
);

   localparam int WCW = $clog2(PKT_WORDS) + 1;
   localparam int ECW = (SCHED_PERIOD > 1) ? $clog2(SCHED_PERIOD) : 1;
   localparam int HCW = (SCHED_LAT > 0) ? $clog2(SCHED_LAT + 1) : 1;

   typedef enum logic {IDLE, XFER} ingState_t;

   logic [ECW-1:0] epochCnt_q, epochCnt_d;
   logic           schedEn_q, schedEn_d;
   logic [HCW-1:0] holdCnt_q, holdCnt_d;
   logic [15:0]    voqEmpty_q, voqEmpty_d;

   ingState_t      state_q   [4];
   ingState_t      state_d   [4];
   logic [WCW-1:0] wcnt_q    [4];
   logic [WCW-1:0] wcnt_d    [4];
   logic [1:0]     busyVoq_q [4];
   logic [1:0]     busyVoq_d [4];

   logic [3:0]     deqEn_q, deqEn_d;
   logic [3:0]     lastWord_d;
   logic [7:0]     deqVoq_q, deqVoq_d;
   logic [3:0]     xValid_q, xValid_d;
   logic [7:0]     xSrc_q, xSrc_d;
   logic [3:0]     xLast_q, xLast_d;
   logic [1:0]     selV;

   // Epoch counter, sched_en pulse, and the snapshot that freezes while the scheduler iterates.
   always_comb begin
      epochCnt_d = (epochCnt_q == ECW'(SCHED_PERIOD - 1)) ? '0 : epochCnt_q + 1'b1;
      schedEn_d  = (epochCnt_q == ECW'(SCHED_PERIOD - 1));
      holdCnt_d  = holdCnt_q;
      voqEmpty_d = voqEmpty_q;
      if (schedEn_q && (SCHED_LAT > 0)) begin
         holdCnt_d = HCW'(SCHED_LAT - 1);
      end else if (holdCnt_q != '0) begin
         holdCnt_d = holdCnt_q - 1'b1;
      end else begin
         voqEmpty_d = voq_empty_in_i;
      end
   end

   // Per-ingress packet FSM; wcnt counts words still to be popped after the current one.
   always_comb begin
      selV       = '0;
      deqEn_d    = '0;
      lastWord_d = '0;
      for (int i = 0; i < 4; i++) begin
         state_d[i]   = state_q[i];
         wcnt_d[i]    = wcnt_q[i];
         busyVoq_d[i] = busyVoq_q[i];
         selV         = sched_sel_i[2*i +: 2];
         case (state_q[i])
            IDLE: begin
               if (sched_sel_en_i[i] && !voq_empty_in_i[4*i + int'(selV)]) begin
                  state_d[i]    = XFER;
                  busyVoq_d[i]  = selV;
                  wcnt_d[i]     = WCW'(PKT_WORDS - 1);
                  deqEn_d[i]    = 1'b1;
                  lastWord_d[i] = (PKT_WORDS == 1);
               end
            end
            XFER: begin
               if (wcnt_q[i] == '0) begin
                  state_d[i]   = IDLE;
                  busyVoq_d[i] = '0;
               end else if (!voq_empty_in_i[4*i + int'(busyVoq_q[i])]) begin
                  wcnt_d[i]     = wcnt_q[i] - 1'b1;
                  deqEn_d[i]    = 1'b1;
                  lastWord_d[i] = (wcnt_q[i] == WCW'(1));
               end
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // Crossbar select; scanning from the top lets the lowest popping ingress win a contested egress.
   always_comb begin
      deqVoq_d = '0;
      xValid_d = '0;
      xSrc_d   = '0;
      xLast_d  = '0;
      for (int i = 3; i >= 0; i--) begin
         if (deqEn_d[i]) begin
            deqVoq_d[2*i +: 2]               = busyVoq_d[i];
            xValid_d[busyVoq_d[i]]           = 1'b1;
            xSrc_d[2*int'(busyVoq_d[i]) +: 2] = 2'(i);
            xLast_d[busyVoq_d[i]]            = lastWord_d[i];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         epochCnt_q <= '0;
         schedEn_q  <= 1'b0;
         holdCnt_q  <= '0;
         voqEmpty_q <= 16'hFFFF;
         deqEn_q    <= '0;
         deqVoq_q   <= '0;
         xValid_q   <= '0;
         xSrc_q     <= '0;
         xLast_q    <= '0;
         for (int i = 0; i < 4; i++) begin
            state_q[i]   <= IDLE;
            wcnt_q[i]    <= '0;
            busyVoq_q[i] <= '0;
         end
      end else begin
         epochCnt_q <= epochCnt_d;
         schedEn_q  <= schedEn_d;
         holdCnt_q  <= holdCnt_d;
         voqEmpty_q <= voqEmpty_d;
         deqEn_q    <= deqEn_d;
         deqVoq_q   <= deqVoq_d;
         xValid_q   <= xValid_d;
         xSrc_q     <= xSrc_d;
         xLast_q    <= xLast_d;
         for (int i = 0; i < 4; i++) begin
            state_q[i]   <= state_d[i];
            wcnt_q[i]    <= wcnt_d[i];
            busyVoq_q[i] <= busyVoq_d[i];
         end
      end
   end

   always_comb begin
      is_busy_o      = '0;
      busy_voq_num_o = '0;
      for (int i = 0; i < 4; i++) begin
         is_busy_o[i]             = (state_q[i] == XFER);
         busy_voq_num_o[2*i +: 2] = busyVoq_q[i];
      end
   end

   assign sched_en_o   = schedEn_q;
   assign voq_empty_o  = voqEmpty_q;
   assign deq_en_o     = deqEn_q;
   assign deq_voq_o    = deqVoq_q;
   assign xbar_valid_o = xValid_q;
   assign xbar_src_o   = xSrc_q;
   assign xbar_last_o  = xLast_q;

`ifdef GRANT_CHECK_EN
   logic       grantErr_q, grantErr_d;
   logic [1:0] selA, selB;

   // Sticky flag for grants the scheduler should never issue and for crossbar collisions.
   always_comb begin
      grantErr_d = grantErr_q;
      selA       = '0;
      selB       = '0;
      for (int i = 0; i < 4; i++) begin
         selA = sched_sel_i[2*i +: 2];
         if (sched_sel_en_i[i]) begin
            if ((state_q[i] == IDLE) && voq_empty_in_i[4*i + int'(selA)]) grantErr_d = 1'b1;
            if ((state_q[i] == XFER) && (selA != busyVoq_q[i]))          grantErr_d = 1'b1;
         end
         for (int j = i + 1; j < 4; j++) begin
            selB = sched_sel_i[2*j +: 2];
            if (sched_sel_en_i[i] && sched_sel_en_i[j] && (selA == selB)) grantErr_d = 1'b1;
            if (deqEn_d[i] && deqEn_d[j] && (busyVoq_d[i] == busyVoq_d[j])) grantErr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         grantErr_q <= 1'b0;
      end else begin
         grantErr_q <= grantErr_d;
      end
   end

   assign grant_err_o = grantErr_q;
`else
   assign grant_err_o = 1'b0;
`endif

endmodule
